timer_irq_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_irq_edge.sv | 21 ++
 rtl/timer_irq_ctrl.sv | 117 +++++++++++
 tb/tb_timer_irq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared timer constants: interrupt controller register offsets and IVR idle value.
package timer_pkg;

    localparam logic [4:0] IRQ_IPR_OFF = 5'h00;
    localparam logic [4:0] IRQ_IER_OFF = 5'h04;
    localparam logic [4:0] IRQ_ISR_OFF = 5'h08;
    localparam logic [4:0] IRQ_IFR_OFF = 5'h0C;
    localparam logic [4:0] IRQ_OVR_OFF = 5'h10;
    localparam logic [4:0] IRQ_IVR_OFF = 5'h14;

    localparam logic [31:0] IVR_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_irq_edge.sv
// Per-bit rising-edge detector; prev resets to 0 so a source high out of reset
// is seen as an edge on the first clock.
module timer_irq_edge #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_vec,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= '0;
        else     r_prev <= i_vec;
    end

    assign o_rise = i_vec & ~r_prev;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt aggregator: sticky pending, enable, masked status, vector.
// Optional overrun tracking at 0x10 is built when TIMER_IRQ_OVERRUN_EN is defined.
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int BITS_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     t_irq,
    input  logic                    tc_irq,
    input  logic                    wen,
    input  logic                    ren,
    input  logic [BITS_WIDTH-1:0]   addr,
    input  logic [BITS_WIDTH-1:0]   wdata,
    input  logic [BITS_WIDTH/8-1:0] strobe,
    output logic [BITS_WIDTH-1:0]   rdata,
    output logic                    error,
    output logic                    irq
);

    localparam int N = CHANNELS + 1;

    logic [N-1:0]          w_src;
    logic [N-1:0]          w_rise;
    logic [N-1:0]          r_ipr;
    logic [N-1:0]          r_ier;
    logic [N-1:0]          w_isr;
    logic [N-1:0]          w_ovr;
    logic [N-1:0]          w_wd;
    logic [N-1:0]          w_bm;
    logic [N-1:0]          w_ipr_clr;
    logic [N-1:0]          w_ipr_set;
    logic [BITS_WIDTH-1:0] w_ivr;
    logic [4:0]            w_off;
    logic                  w_valid;
    logic                  w_ro;
    logic                  w_wr;

    assign w_src = {tc_irq, t_irq};

    timer_irq_edge #(.WIDTH(N)) u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_vec  (w_src),
        .o_rise (w_rise)
    );

    always_comb begin
        w_bm = '0;
        for (int i = 0; i < N; i++) w_bm[i] = strobe[i/8];
    end

    assign w_off   = addr[4:0];
    assign w_valid = (addr[1:0] == 2'b00) && (addr[4:2] < 3'd6);
    assign w_ro    = (w_off == IRQ_ISR_OFF) || (w_off == IRQ_IVR_OFF);
    assign w_wr    = wen && w_valid && !w_ro;
    assign w_wd    = wdata[N-1:0] & w_bm;

    assign w_ipr_clr = (w_wr && w_off == IRQ_IPR_OFF) ? w_wd : '0;
    assign w_ipr_set = w_rise | ((w_wr && w_off == IRQ_IFR_OFF) ? w_wd : '0);

    // set beats clear on the same bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ipr <= '0;
            r_ier <= '0;
        end else begin
            r_ipr <= (r_ipr & ~w_ipr_clr) | w_ipr_set;
            if (w_wr && w_off == IRQ_IER_OFF)
                r_ier <= (r_ier & ~w_bm) | w_wd;
        end
    end

`ifdef TIMER_IRQ_OVERRUN_EN
    logic [N-1:0] r_ovr;
    logic [N-1:0] w_ovr_clr;

    assign w_ovr_clr = (w_wr && w_off == IRQ_OVR_OFF) ? w_wd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ovr <= '0;
        else     r_ovr <= (r_ovr & ~w_ovr_clr) | (w_rise & r_ipr & ~w_ipr_clr);
    end

    assign w_ovr = r_ovr;
`else
    assign w_ovr = '0;
`endif

    assign w_isr = r_ipr & r_ier;
    assign irq   = |w_isr;

    always_comb begin
        w_ivr = IVR_NONE;
        for (int i = N - 1; i >= 0; i--)
            if (w_isr[i]) w_ivr = BITS_WIDTH'(i);
    end

    always_comb begin
        rdata = '0;
        if (ren && !rst && w_valid) begin
            unique case (w_off)
                IRQ_IPR_OFF: rdata[N-1:0] = r_ipr;
                IRQ_IER_OFF: rdata[N-1:0] = r_ier;
                IRQ_ISR_OFF: rdata[N-1:0] = w_isr;
                IRQ_OVR_OFF: rdata[N-1:0] = w_ovr;
                IRQ_IVR_OFF: rdata        = w_ivr;
                default:     rdata        = '0;
            endcase
        end
    end

    assign error = !rst && (wen || ren) && (!w_valid || (wen && w_ro));

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl with hand-computed expectations.
module tb_timer_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  t_irq = '0;
    logic        tc_irq = 1'b0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  strobe = '0;
    logic [31:0] rdata;
    logic        error;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] v;
    logic        e;

`ifdef TIMER_IRQ_OVERRUN_EN
    localparam logic [31:0] OVR_EXP = 32'h08;
`else
    localparam logic [31:0] OVR_EXP = 32'h00;
`endif

    timer_irq_ctrl #(.CHANNELS(8), .BITS_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .t_irq  (t_irq),
        .tc_irq (tc_irq),
        .wen    (wen),
        .ren    (ren),
        .addr   (addr),
        .wdata  (wdata),
        .strobe (strobe),
        .rdata  (rdata),
        .error  (error),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic er);
        @(negedge clk);
        ren = 1'b1;
        addr = a;
        #1;
        d = rdata;
        er = error;
        ren = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic er);
        @(negedge clk);
        wen = 1'b1;
        addr = a;
        wdata = d;
        strobe = s;
        #1;
        er = error;
        @(negedge clk);
        wen = 1'b0;
        strobe = '0;
    endtask

    task automatic pulse(input logic [7:0] t, input logic tc);
        @(negedge clk);
        t_irq = t;
        tc_irq = tc;
        @(negedge clk);
        t_irq = '0;
        tc_irq = 1'b0;
    endtask

    initial begin
        // in reset
        @(negedge clk);
        ren = 1'b1;
        addr = 32'h14;
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        rd(32'h00, v, e); chk("ipr0", v, 32'h0);
        rd(32'h04, v, e); chk("ier0", v, 32'h0);
        rd(32'h08, v, e); chk("isr0", v, 32'h0);
        rd(32'h14, v, e); chk("ivr0", v, 32'hFFFF_FFFF);
        chk("err0", {31'b0, e}, 32'h0);

        // single channel path
        wr(32'h04, 32'h80, 4'hF, e);
        @(negedge clk);
        t_irq = 8'h80;
        #1;
        chk("irq_nocomb", {31'b0, irq}, 32'h0);
        @(negedge clk);
        t_irq = '0;
        #1;
        chk("irq_rise", {31'b0, irq}, 32'h1);
        rd(32'h00, v, e); chk("ipr_ch7", v, 32'h80);
        rd(32'h14, v, e); chk("ivr_ch7", v, 32'h7);
        wr(32'h00, 32'h80, 4'hF, e);
        #1;
        chk("irq_fall", {31'b0, irq}, 32'h0);

        // tc plus channel, priority
        wr(32'h04, 32'h100, 4'hF, e);
        pulse(8'h04, 1'b1);
        rd(32'h00, v, e); chk("ipr_tc", v, 32'h104);
        rd(32'h08, v, e); chk("isr_tc", v, 32'h100);
        rd(32'h14, v, e); chk("ivr_tc", v, 32'h8);
        wr(32'h04, 32'h104, 4'hF, e);
        rd(32'h14, v, e); chk("ivr_ch2", v, 32'h2);
        wr(32'h00, 32'hFFFF_FFFF, 4'hF, e);
        rd(32'h00, v, e); chk("ipr_clr", v, 32'h0);

        // overrun, then set-wins-clear
        pulse(8'h08, 1'b0);
        pulse(8'h08, 1'b0);
        rd(32'h10, v, e); chk("ovr_set", v, OVR_EXP);
        wr(32'h10, 32'h08, 4'hF, e);
        chk("ovr_wr_err", {31'b0, e}, 32'h0);
        rd(32'h10, v, e); chk("ovr_clr", v, 32'h0);
        @(negedge clk);
        t_irq = 8'h08;
        wen = 1'b1;
        addr = 32'h00;
        wdata = 32'h08;
        strobe = 4'hF;
        @(negedge clk);
        t_irq = '0;
        wen = 1'b0;
        strobe = '0;
        rd(32'h00, v, e); chk("set_wins", v, 32'h08);
        rd(32'h10, v, e); chk("ovr_noset", v, 32'h0);
        wr(32'h00, 32'h08, 4'hF, e);

        // held level does not re-set
        @(negedge clk);
        t_irq = 8'h20;
        @(negedge clk);
        rd(32'h00, v, e); chk("lvl_set", v, 32'h20);
        wr(32'h00, 32'h20, 4'hF, e);
        @(negedge clk);
        rd(32'h00, v, e); chk("lvl_hold", v, 32'h0);
        t_irq = '0;

        // IFR with strobes
        wr(32'h0C, 32'h01, 4'h0, e);
        rd(32'h00, v, e); chk("ifr_nostb", v, 32'h0);
        wr(32'h0C, 32'h01, 4'h1, e);
        rd(32'h00, v, e); chk("ifr_stb", v, 32'h01);
        wr(32'h04, 32'h1FF, 4'h2, e);
        rd(32'h04, v, e); chk("ier_stb", v, 32'h104);

        // bad accesses
        rd(32'h18, v, e);
        chk("err_18", {31'b0, e}, 32'h1);
        chk("rd_18", v, 32'h0);
        rd(32'h02, v, e);
        chk("err_02", {31'b0, e}, 32'h1);
        chk("rd_02", v, 32'h0);
        wr(32'h08, 32'hFFFF_FFFF, 4'hF, e);
        chk("err_wisr", {31'b0, e}, 32'h1);
        wr(32'h1C, 32'hFFFF_FFFF, 4'hF, e);
        chk("err_w1c", {31'b0, e}, 32'h1);
        rd(32'h00, v, e); chk("ipr_keep", v, 32'h01);
        rd(32'h04, v, e); chk("ier_keep", v, 32'h104);

        // simultaneous read/write returns old value
        @(negedge clk);
        wen = 1'b1;
        ren = 1'b1;
        addr = 32'h04;
        wdata = 32'h0F;
        strobe = 4'hF;
        #1;
        chk("rw_old", rdata, 32'h104);
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
        strobe = '0;
        rd(32'h04, v, e); chk("rw_new", v, 32'h0F);
        chk("irq_on", {31'b0, irq}, 32'h1);

        // async reset mid-run
        #2;
        rst = 1'b1;
        #1;
        chk("arst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        rd(32'h00, v, e); chk("arst_ipr", v, 32'h0);
        rd(32'h04, v, e); chk("arst_ier", v, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
